uart_rx: RTL and testbench

- Receive counterpart to the memory-mapped UART transmit path.
- Deserialises an 8N1 asynchronous serial line into bytes and buffers them in a small FIFO.
- Presents the FIFO head, status and error flags to the MMIO block for CPU reads.
- Sits between the board RX pin and mmio; the CPU pops bytes through a read-side strobe.

---
 rtl/uart.sv | 19 +
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart.sv
// rtl/uart.sv - shared types and helpers for the UART receive path.
package uart;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int DATA_BITS = 8;

   // Parity bit value that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small receive FIFO with combinational head and occupancy count.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign rd_en = pop & (count != '0);
   assign wr_en = push & (~full | rd_en);
   assign head  = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with FIFO and sticky error flags.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables parity_err.
module uart_rx
   import uart::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clk_enable,
   input  logic                          rx,
   input  logic                          pop,
   input  logic                          clear_err,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overrun,
   output logic                          frame_err,
   output logic                          parity_err
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e     state;
   logic [1:0]    sync;
   logic          rx_s;
   logic          rx_prev;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          tick;
   logic          clr;
   logic          pop_acc;
   logic          push_req;
   logic          fe_set;
   logic          ov_set;
   logic          full;

   assign rx_s     = sync[1];
   assign tick     = (baud_cnt == '0);
   assign clr      = clear_err & clk_enable;
   assign pop_acc  = pop & clk_enable & rx_valid;
   assign fe_set   = (state == STOP) && tick && !rx_s;
   assign ov_set   = push_req && full && !pop_acc;
   assign rx_valid = (rx_count != '0);

`ifdef UART_RX_PARITY_EN
   logic par_bad;
   logic pe_set;
   logic parity_err_r;
   assign pe_set     = (state == PARITY) && tick && (even_parity(shift) != rx_s);
   assign push_req   = (state == STOP) && tick && rx_s && !par_bad;
   assign parity_err = parity_err_r;
`else
   assign push_req   = (state == STOP) && tick && rx_s;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sync      <= 2'b11;
         rx_prev   <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad      <= 1'b0;
         parity_err_r <= 1'b0;
`endif
      end else begin
         sync      <= {sync[0], rx};
         rx_prev   <= rx_s;
         // A new error in the same cycle as a clear keeps the flag set.
         overrun   <= ov_set | (overrun & ~clr);
         frame_err <= fe_set | (frame_err & ~clr);
`ifdef UART_RX_PARITY_EN
         parity_err_r <= pe_set | (parity_err_r & ~clr);
`endif
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  baud_cnt <= HALF_LOAD;
                  state    <= START;
               end
            end
            START: begin
               if (!tick) begin
                  baud_cnt <= baud_cnt - BW'(1);
               end else if (!rx_s) begin
                  baud_cnt <= FULL_LOAD;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (!tick) begin
                  baud_cnt <= baud_cnt - BW'(1);
               end else begin
                  shift    <= {rx_s, shift[7:1]};
                  baud_cnt <= FULL_LOAD;
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (!tick) begin
                  baud_cnt <= baud_cnt - BW'(1);
               end else begin
                  par_bad  <= pe_set;
                  baud_cnt <= FULL_LOAD;
                  state    <= STOP;
               end
            end
`endif
            STOP: begin
               if (!tick) baud_cnt <= baud_cnt - BW'(1);
               else       state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_req),
      .push_data (shift),
      .pop       (pop_acc),
      .head      (rx_data),
      .count     (rx_count),
      .full      (full)
   );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int POP_AT = CPB * (NBITS - 1) + 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_enable = 1'b1;
   logic       rx = 1'b1;
   logic       pop = 1'b0;
   logic       clear_err = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] rx_count;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .rx(rx), .pop(pop),
      .clear_err(clear_err), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err),
      .parity_err(parity_err));

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic       exp_ov = 1'b0, exp_fe = 1'b0, exp_pe = 1'b0;
   int         cyc = 0;
   int         rise_cyc = -1;
   logic       vprev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted pop must hand out the oldest expected byte.
   initial forever begin
      @(negedge clk);
      #4;
      if (rst_n && pop && clk_enable) begin
         check("pop_valid", {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) check("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
   end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rx_valid && !vprev && rise_cyc < 0) rise_cyc = cyc;
      vprev = rx_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: a frame is kept only if stop is high and parity is even; a full FIFO drops it.
   task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
      logic par_ok;
`ifdef UART_RX_PARITY_EN
      par_ok = ((^d) ^ par) == 1'b0;
`else
      par_ok = 1'b1;
`endif
      if (!stop)   exp_fe = 1'b1;
      if (!par_ok) exp_pe = 1'b1;
      if (stop && par_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else                      exp_ov = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int pop_at);
      logic b[11];
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
      b[9]  = (NBITS == 11) ? par : stop;
      b[10] = stop;
      for (int c = 0; c < NBITS * CPB; c++) begin
         @(negedge clk);
         rx  = b[c / CPB];
         pop = (c == pop_at);
      end
      @(negedge clk);
      rx  = 1'b1;
      pop = 1'b0;
      model_frame(d, stop, par);
   endtask

   task automatic checkpoint(input string tag);
      @(negedge clk);
      #4;
      check({tag, ":count"}, {29'd0, rx_count}, exp_q.size());
      check({tag, ":valid"}, {31'd0, rx_valid}, {31'd0, exp_q.size() != 0});
      check({tag, ":data"}, {24'd0, rx_data}, (exp_q.size() != 0) ? {24'd0, exp_q[0]} : 32'd0);
      check({tag, ":overrun"}, {31'd0, overrun}, {31'd0, exp_ov});
      check({tag, ":frame_err"}, {31'd0, frame_err}, {31'd0, exp_fe});
      check({tag, ":parity_err"}, {31'd0, parity_err}, {31'd0, exp_pe});
   endtask

   task automatic do_pop();
      @(negedge clk);
      pop = 1'b1;
      clk_enable = 1'b1;
      @(negedge clk);
      pop = 1'b0;
   endtask

   task automatic do_clear(input logic ce);
      @(negedge clk);
      clear_err = 1'b1;
      clk_enable = ce;
      @(negedge clk);
      clear_err = 1'b0;
      clk_enable = 1'b1;
      if (ce) begin
         exp_ov = 1'b0;
         exp_fe = 1'b0;
         exp_pe = 1'b0;
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 2 * DEPTH && exp_q.size() != 0; g++) do_pop();
   endtask

   initial begin
      logic [7:0] d;
      int         start_cyc;
      int         lat;

      repeat (3) @(negedge clk);
      checkpoint("in_reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkpoint("after_reset");

      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      lat = rise_cyc - start_cyc;
      check("latency_window", {31'd0, rise_cyc >= 0 && lat >= 9 * CPB && lat <= 10 * CPB + 4}, 32'd1);
      checkpoint("a5");
      do_pop();
      checkpoint("a5_popped");

      @(negedge clk);
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checkpoint("glitch");
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      checkpoint("after_glitch");
      drain();

      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
      checkpoint("overrun");
      drain();
      checkpoint("overrun_drained");
      do_clear(1'b1);

      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1, ^d, -1);
      end
      d = 8'($urandom);
      send_frame(d, 1'b1, ^d, POP_AT);
      checkpoint("push_pop_full");
      drain();
      checkpoint("push_pop_drained");

      send_frame(8'h55, 1'b0, 1'b0, -1);
      checkpoint("frame_err");
      do_clear(1'b0);
      checkpoint("clear_gated");
      do_clear(1'b1);
      checkpoint("clear_done");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, -1);
      checkpoint("parity_ok");
      send_frame(8'h07, 1'b1, 1'b0, -1);
      checkpoint("parity_bad");
      drain();
      do_clear(1'b1);
`endif

      for (int i = 0; i < 10; i++) begin
         d = 8'($urandom);
         send_frame(d, $urandom_range(0, 4) != 0, (^d) ^ ($urandom_range(0, 3) == 0), -1);
         if ($urandom_range(0, 1) == 1) do_pop();
         checkpoint("random");
      end

      if (exp_q.size() == 0) send_frame(8'h99, 1'b1, ^8'h99, -1);
      @(negedge clk);
      rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      exp_ov = 1'b0;
      exp_fe = 1'b0;
      exp_pe = 1'b0;
      checkpoint("mid_frame_reset");
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (CPB) @(negedge clk);
      d = 8'($urandom);
      send_frame(d, 1'b1, ^d, -1);
      checkpoint("post_reset_frame");
      drain();
      checkpoint("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
